request_acceptor: RTL and testbench
===================================

Name: request_acceptor

Overview:
- Upstream handshake stage that generates the `request`/`accept`/`cancel`/`busy` protocol consumed by the accepted-request checker.
- Latches a job request and holds off acceptance for a minimum delay.
- Accepts the job when the downstream is ready, unless the job was cancelled.
- Drives `busy` for a job-length-controlled window whose rising edge coincides exactly with the `accept` pulse.

Parameters:
- MIN_DELAY, 4, minimum cycles from request sample to earliest accept (>=1).
- MAX_WAIT, 16, wait-cycle limit used only with REQ_TIMEOUT_EN (>MIN_DELAY).
- LEN_W, 8, width of job_len.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- request  in  1  job request; sampled only in IDLE.
- job_len  in  LEN_W  busy duration in cycles, sampled with request; 0 is treated as 1.
- cancel  in  1  aborts a pending request in WAIT.
- ready  in  1  downstream can take a job.
- accept  out  1  one-cycle acceptance pulse.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse on the last busy cycle.
- timeout  out  1  one-cycle pulse on a wait abort; constant 0 without REQ_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, accept=busy=done=timeout=0, counters=0. rst asserted in any state returns to IDLE on the next edge, with no accept/done pulse.
- IDLE -> WAIT when request=1.
  - Latch len = (job_len==0 ? 1 : job_len).
  - Load wait_cnt=1.
  - cancel in the same cycle is ignored.
- WAIT, each cycle:
  - cancel=1 -> IDLE; no accept ever issues for this request. Cancel has priority over acceptance in the same cycle.
  - Else if wait_cnt>=MIN_DELAY and ready=1 -> BUSY. accept=1 and busy=1 in the same output cycle; busy_cnt=len.
  - Else wait_cnt++ (saturating).
- Timing: request sampled at edge t gives accept visible no earlier than cycle t+MIN_DELAY. accept=0 for cycles t..t+MIN_DELAY-1, so request |-> !accept[*MIN_DELAY] holds.
- BUSY:
  - busy=1, accept=0 after the first cycle; busy_cnt decrements each cycle.
  - On the cycle with busy_cnt==1: done=1; next state IDLE; busy falls next cycle.
  - Total busy high = len cycles, including the accept cycle.
  - cancel and request are ignored in BUSY. Requests are never queued; a request outside IDLE is dropped.
- Back-to-back operation: a request in the first IDLE cycle after busy falls is accepted. A minimum one-cycle busy-low gap is guaranteed, so every $rose(busy) coincides with accept.
- Invariants:
  - accept implies busy.
  - $rose(busy) implies accept.
  - accept is never asserted without a preceding request and no cancel since.
  - done is asserted at most once per accept.

Optional Feature:
- Macro: REQUEST_ACCEPTOR_TIMEOUT_EN.
- Defined:
  - In WAIT, if wait_cnt reaches MAX_WAIT without acceptance -> IDLE, with timeout=1 for one cycle.
  - cancel in that same cycle takes priority; timeout stays 0.
- Undefined:
  - WAIT persists until ready or cancel.
  - timeout is tied to 0; the wait_cnt saturation width stays sized for MIN_DELAY only.

Decomposition:
- Package request_acceptor_pkg holds:
  - state enum {IDLE, WAIT, BUSY};
  - function sat_len(job_len) implementing the 0→1 mapping.
- One natural sub-module: busy_timer (load len, decrement, done flag), reusable by later busy-generating stages.
- Waiting counter and FSM live in the top level.

Test Plan:
- MIN_DELAY=4, ready=1, request at cycle 0, job_len=3 -> accept=busy=1 at cycle 4; busy cycles 4-6; done at 6; idle at 7.
- request at 0, cancel at 2, ready=1 -> no accept, busy stays 0; a new request at 5 is accepted at 9.
- request at 0, ready=0 until 10, cancel at 10 -> cancel wins: no accept at 10, state IDLE at 11.
- job_len=0 -> busy exactly 1 cycle; accept and done in the same cycle.
- rst asserted mid-BUSY (busy_cnt=5) -> next cycle busy=0, done=0; a request two cycles later is accepted after MIN_DELAY.
- With REQUEST_ACCEPTOR_TIMEOUT_EN, MAX_WAIT=16, ready=0 -> timeout pulse 16 cycles after the request, no accept. Without the macro, same stimulus -> still WAIT at cycle 40; accept the cycle ready rises.

Source files
------------

// File: rtl/request_acceptor_pkg.sv
// request_acceptor shared types and helpers.
// Holds the FSM state encoding and the job-length mapping.
package request_acceptor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BUSY
  } state_t;

  // A zero-length job still occupies one busy cycle.
  function automatic int unsigned sat_len(
    input int unsigned job_len
  );
    return (job_len == 0) ? 1 : job_len;
  endfunction

endpackage

// File: rtl/request_acceptor_if.sv
// request_acceptor handshake bundle.
// master drives request/job_len/cancel/ready; slave answers.
interface request_acceptor_if #(
  parameter int LEN_W = 8
);
  import request_acceptor_pkg::*;

  logic             request;
  logic [LEN_W-1:0] job_len;
  logic             cancel;
  logic             ready;
  logic             accept;
  logic             busy;
  logic             done;
  logic             timeout;

  modport master (
    output request, job_len, cancel, ready,
    input  accept, busy, done, timeout
  );

  modport slave (
    input  request, job_len, cancel, ready,
    output accept, busy, done, timeout
  );

endinterface

// File: rtl/request_acceptor_busy_timer.sv
// Busy window generator: load a length, count down, flag last cycle.
// busy and done are registered; len must be >= 1 when loaded.
module request_acceptor_busy_timer
  import request_acceptor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= len;
      busy <= 1'b1;
      done <= (len == W'(1));
    end else if (busy) begin
      cnt  <= cnt - W'(1);
      busy <= (cnt != W'(1));
      done <= (cnt == W'(2));
    end
  end

endmodule

// File: rtl/request_acceptor.sv
// Request/accept/cancel/busy handshake generator with min accept delay.
// Define REQUEST_ACCEPTOR_TIMEOUT_EN to abort waits at MAX_WAIT cycles.
module request_acceptor
  import request_acceptor_pkg::*;
#(
  parameter int MIN_DELAY = 4,
  parameter int MAX_WAIT  = 16,
  parameter int LEN_W     = 8
) (
  input logic               clk,
  input logic               rst,
  request_acceptor_if.slave bus
);

`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int WLIM = TMO_EN ? MAX_WAIT : MIN_DELAY;
  localparam int WCW  = $clog2(WLIM + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_nxt;
  logic [LEN_W-1:0] len_q;
  logic             acc_nxt;
  logic             acc_q;
  logic             tm_busy;
  logic             tm_done;
`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
  logic             to_nxt;
  logic             to_q;
`endif

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    acc_nxt   = 1'b0;
`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
    to_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.request) begin
          state_nxt = WAIT;
          wait_nxt  = WCW'(1);
        end
      end
      WAIT: begin
        // cancel beats accept, accept beats timeout
        if (bus.cancel) begin
          state_nxt = IDLE;
        end else if (wait_cnt >= WCW'(MIN_DELAY)
                     && bus.ready) begin
          state_nxt = BUSY;
          acc_nxt   = 1'b1;
`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
        end else if (wait_cnt >= WCW'(MAX_WAIT)) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
`endif
        end else if (wait_cnt < WCW'(WLIM)) begin
          wait_nxt = wait_cnt + WCW'(1);
        end
      end
      BUSY: begin
        if (tm_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      len_q    <= '0;
      acc_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      acc_q    <= acc_nxt;
      if (state == IDLE && bus.request)
        len_q <= LEN_W'(sat_len(32'(bus.job_len)));
    end
  end

`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_q <= 1'b0;
    else     to_q <= to_nxt;
  end
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  request_acceptor_busy_timer #(
    .W(LEN_W)
  ) u_busy_timer (
    .clk (clk),
    .rst (rst),
    .load(acc_nxt),
    .len (len_q),
    .busy(tm_busy),
    .done(tm_done)
  );

  assign bus.accept = acc_q;
  assign bus.busy   = tm_busy;
  assign bus.done   = tm_done;

endmodule

// File: tb/tb_request_acceptor.sv
// Scoreboard bench for request_acceptor: directed scenarios + random.
// Reference model predicts {accept,busy,done,timeout} per cycle.
module tb_request_acceptor;

  localparam int MIN_DELAY = 4;
  localparam int MAX_WAIT  = 16;
  localparam int LEN_W     = 8;

`ifdef REQUEST_ACCEPTOR_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  request_acceptor_if #(.LEN_W(LEN_W)) bus ();

  request_acceptor #(
    .MIN_DELAY(MIN_DELAY),
    .MAX_WAIT (MAX_WAIT),
    .LEN_W    (LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting, 2 busy
  int       phase   = 0;
  int       waited  = 0;
  int       job     = 0;
  int       remain  = 0;
  int       cyc     = 0;
  logic [3:0] sb[$];

  always @(posedge clk) begin
    logic a, b, d, t;
    a = 0; b = 0; d = 0; t = 0;
    cyc++;
    if (rst) begin
      phase = 0;
    end else if (phase == 0) begin
      if (bus.request) begin
        phase  = 1;
        waited = 1;
        job    = (bus.job_len == 0) ? 1 : int'(bus.job_len);
      end
    end else if (phase == 1) begin
      if (bus.cancel) begin
        phase = 0;
      end else if (waited >= MIN_DELAY && bus.ready) begin
        phase  = 2;
        remain = job;
        a = 1; b = 1; d = (remain == 1);
      end else if (TMO && waited >= MAX_WAIT) begin
        phase = 0;
        t = 1;
      end else begin
        waited++;
      end
    end else begin
      remain--;
      if (remain == 0) begin
        phase = 0;
      end else begin
        b = 1;
        d = (remain == 1);
      end
    end
    sb.push_back({a, b, d, t});
  end

  // ---------------- monitor ----------------
  int compared   = 0;
  int mismatched = 0;
  int accepts    = 0;

  always @(negedge clk) begin
    logic [3:0] exp, got;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {bus.accept, bus.busy, bus.done, bus.timeout};
      compared++;
      if (got[3]) accepts++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL outputs cyc=%0d acc/busy/done/to got=%b want=%b",
                 cyc, got, exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic q,
                      input int l, input logic c,
                      input logic y);
    rst          = r;
    bus.request  = q;
    bus.job_len  = LEN_W'(l);
    bus.cancel   = c;
    bus.ready    = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic y);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, y);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 5, 1, 1);
    step(1, 0, 0, 0, 0);

    // basic job, len 3
    step(0, 1, 3, 0, 1);
    idle(10, 1);

    // cancel during wait, then fresh request
    step(0, 1, 4, 0, 1);
    idle(1, 1);
    step(0, 0, 0, 1, 1);
    idle(2, 1);
    step(0, 1, 2, 0, 1);
    idle(10, 1);

    // long stall, cancel coinciding with ready
    step(0, 1, 2, 0, 0);
    idle(9, 0);
    step(0, 0, 0, 1, 1);
    idle(4, 1);

    // zero-length job
    step(0, 1, 0, 0, 1);
    idle(8, 1);

    // reset mid-busy, requests ignored while busy
    step(0, 1, 9, 0, 1);
    idle(5, 1);
    step(0, 1, 3, 1, 1);
    step(1, 0, 0, 0, 1);
    idle(1, 1);
    step(0, 1, 2, 0, 1);
    idle(10, 1);

    // long wait with ready low, then ready rises
    step(0, 1, 2, 0, 0);
    idle(40, 0);
    idle(8, 1);

    // back-to-back requests held high
    for (int i = 0; i < 30; i++) step(0, 1, 1, 0, 1);
    idle(4, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 4),
           $urandom_range(0, 7),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6));
    end
    idle(12, 1);
    @(negedge clk);
    #1;

    compared++;
    if (accepts < 50) begin
      mismatched++;
      $display("FAIL activity accepts got=%0d want>=50", accepts);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
